// File: rtl/core_symbols_pkg.sv
// ---------------------------------------------------------------------------
// core_symbols
// Shared symbols for the RISC integer pipeline operand-bypass logic.
//   - one-hot select encodings for the ALU operand / writeback register stage
//     (A, BR, BI operand selects and the writeback-register select)
//   - select and register-number widths
//   - the per-stage destination-tracking record used by fwd_ctl / fwd_hit
//   - trk_hit(): "does this in-flight entry produce register r" test
// ---------------------------------------------------------------------------
package core_symbols;

  // Widths of the select buses and register numbers
  localparam int RALU_SA_W  = 9;
  localparam int RALU_SBR_W = 7;
  localparam int RALU_SBI_W = 8;
  localparam int RALU_SC_W  = 4;
  localparam int REG_W      = 5;

  // A-operand select (bits 0-8)
  localparam logic [RALU_SA_W-1:0] RALU_SA_IMMED    = 9'b0_0000_0001;
  localparam logic [RALU_SA_W-1:0] RALU_SA_ALURES   = 9'b0_0000_0010;
  localparam logic [RALU_SA_W-1:0] RALU_SA_ALUREGM  = 9'b0_0000_0100;
  localparam logic [RALU_SA_W-1:0] RALU_SA_REGAHOLD = 9'b0_0000_1000;
  localparam logic [RALU_SA_W-1:0] RALU_SA_DBUS     = 9'b0_0001_0000;
  localparam logic [RALU_SA_W-1:0] RALU_SA_REGCWB   = 9'b0_0010_0000;
  localparam logic [RALU_SA_W-1:0] RALU_SA_PCREL    = 9'b0_0100_0000;
  localparam logic [RALU_SA_W-1:0] RALU_SA_REGASF   = 9'b0_1000_0000;
  localparam logic [RALU_SA_W-1:0] RALU_SA_RESET    = 9'b1_0000_0000;

  // BR-operand select (bits 0-6)
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_ALURES    = 7'b000_0001;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_ALUREGM   = 7'b000_0010;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_REGBRHOLD = 7'b000_0100;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_DBUS      = 7'b000_1000;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_REGCWB    = 7'b001_0000;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_REGBSF    = 7'b010_0000;
  localparam logic [RALU_SBR_W-1:0] RALU_SBR_RESET     = 7'b100_0000;

  // BI-operand select: IMMED in bit 0, the BR set shifted up by one
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_IMMED     = 8'b0000_0001;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_ALURES    = 8'b0000_0010;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_ALUREGM   = 8'b0000_0100;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_REGBRHOLD = 8'b0000_1000;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_DBUS      = 8'b0001_0000;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_REGCWB    = 8'b0010_0000;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_REGBSF    = 8'b0100_0000;
  localparam logic [RALU_SBI_W-1:0] RALU_SBI_RESET     = 8'b1000_0000;

  // Writeback-register select (bits 0-3)
  localparam logic [RALU_SC_W-1:0] RALU_SC_RESET   = 4'b0001;
  localparam logic [RALU_SC_W-1:0] RALU_SC_DBUS    = 4'b0010;
  localparam logic [RALU_SC_W-1:0] RALU_SC_HOLD    = 4'b0100;
  localparam logic [RALU_SC_W-1:0] RALU_SC_ALUREGM = 4'b1000;

  // One in-flight instruction as seen by the bypass network
  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             load;
    logic [REG_W-1:0] rd;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '0;

  // Register 0 is hardwired, so a writer of r0 never produces a bypass
  function automatic logic trk_hit(input trk_entry_t ent, input logic [REG_W-1:0] r);
    return ent.valid & ent.wen & (ent.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_ctl_hit.sv
// ---------------------------------------------------------------------------
// fwd_hit
// Compares one source register number against the E, M and W tracking
// entries and reports which in-flight stages would supply its value.
//   ent_e/ent_m/ent_w  in   tracking entries of the E, M, W stages
//   reg_num            in   source register number being resolved
//   hit_e              out  E stage writes reg_num
//   hit_m              out  M stage writes reg_num
//   hit_m_load         out  M stage writes reg_num and is a load
//   hit_w              out  W stage writes reg_num
// ---------------------------------------------------------------------------
module fwd_hit
  import core_symbols::*;
(
  input  trk_entry_t       ent_e,
  input  trk_entry_t       ent_m,
  input  trk_entry_t       ent_w,
  input  logic [REG_W-1:0] reg_num,
  output logic             hit_e,
  output logic             hit_m,
  output logic             hit_m_load,
  output logic             hit_w
);

  assign hit_e      = trk_hit(ent_e, reg_num);
  assign hit_m      = trk_hit(ent_m, reg_num);
  // A load in M has its data on RDBUSINM rather than in the M result register
  assign hit_m_load = hit_m & ent_m.load;
  assign hit_w      = trk_hit(ent_w, reg_num);

endmodule

// File: rtl/fwd_ctl.sv
// ---------------------------------------------------------------------------
// fwd_ctl
// Operand-bypass and load-use interlock controller for the S->E->M->W
// integer pipeline. Tracks destinations of the instructions in E, M and W
// and produces the one-hot operand selects for the instruction in S.
//   SYSCLK        in   pipeline clock
//   RESET_D1_R_N  in   asynchronous active-low reset
//   CLMI_RHOLD    in   global hold, freezes tracking state
//   VALID_S       in   S holds a real instruction
//   RS_S/RT_S     in   source register numbers
//   USES_RS_S/USES_RT_S in  instruction reads RS / RT
//   RD_S, WEN_S   in   destination register and its write enable
//   LOAD_S        in   instruction is a load
//   USE_SHAMT_S, USE_PC_S, USE_IMM_S  in  immediate-style operand overrides
//   SELA_S, SELBR_S, SELBI_S  out  operand selects (one-hot)
//   SELC_M        out  writeback-register select (one-hot)
//   STALL_S       out  load-use interlock, S re-presents the same instruction
// ---------------------------------------------------------------------------
module fwd_ctl
  import core_symbols::*;
(
  input  logic                  SYSCLK,
  input  logic                  RESET_D1_R_N,
  input  logic                  CLMI_RHOLD,
  input  logic                  VALID_S,
  input  logic [REG_W-1:0]      RS_S,
  input  logic [REG_W-1:0]      RT_S,
  input  logic                  USES_RS_S,
  input  logic                  USES_RT_S,
  input  logic [REG_W-1:0]      RD_S,
  input  logic                  WEN_S,
  input  logic                  LOAD_S,
  input  logic                  USE_SHAMT_S,
  input  logic                  USE_PC_S,
  input  logic                  USE_IMM_S,
  output logic [RALU_SA_W-1:0]  SELA_S,
  output logic [RALU_SBR_W-1:0] SELBR_S,
  output logic [RALU_SBI_W-1:0] SELBI_S,
  output logic [RALU_SC_W-1:0]  SELC_M,
  output logic                  STALL_S
);

  trk_entry_t ent_e, ent_m, ent_w;
  logic       init_r;
  logic       stall_raw;
  logic       rs_hit_e, rs_hit_m, rs_hit_m_load, rs_hit_w;
  logic       rt_hit_e, rt_hit_m, rt_hit_m_load, rt_hit_w;

  fwd_hit u_hit_rs (
    .ent_e      (ent_e),
    .ent_m      (ent_m),
    .ent_w      (ent_w),
    .reg_num    (RS_S),
    .hit_e      (rs_hit_e),
    .hit_m      (rs_hit_m),
    .hit_m_load (rs_hit_m_load),
    .hit_w      (rs_hit_w)
  );

  fwd_hit u_hit_rt (
    .ent_e      (ent_e),
    .ent_m      (ent_m),
    .ent_w      (ent_w),
    .reg_num    (RT_S),
    .hit_e      (rt_hit_e),
    .hit_m      (rt_hit_m),
    .hit_m_load (rt_hit_m_load),
    .hit_w      (rt_hit_w)
  );

  // A load in E has no data yet. RS is exempt when the A operand is
  // replaced by the shift amount or the PC, since RS is then not consumed.
  assign stall_raw = VALID_S & ent_e.valid & ent_e.load & ent_e.wen & (ent_e.rd != '0) &
                     ((USES_RS_S & (ent_e.rd == RS_S) & ~USE_SHAMT_S & ~USE_PC_S) |
                      (USES_RT_S & (ent_e.rd == RT_S)));

  assign STALL_S = ~init_r & stall_raw;

  // Tracking shift register. The hold freezes it even when a stall is
  // requested, so no bubble is inserted while held.
  always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      init_r <= 1'b1;
      ent_e  <= TRK_BUBBLE;
      ent_m  <= TRK_BUBBLE;
      ent_w  <= TRK_BUBBLE;
    end else begin
      init_r <= 1'b0;
      if (!CLMI_RHOLD) begin
        ent_w <= ent_m;
        ent_m <= ent_e;
        if (stall_raw || !VALID_S) begin
          ent_e <= TRK_BUBBLE;
        end else begin
          ent_e <= '{valid: 1'b1, wen: WEN_S, load: LOAD_S, rd: RD_S};
        end
      end
    end
  end

  // Operand select priority chains; the youngest producer (E) wins
  always_comb begin
    SELA_S  = RALU_SA_REGASF;
    SELBR_S = RALU_SBR_REGBSF;
    SELBI_S = RALU_SBI_REGBSF;

    if (init_r) begin
      SELA_S  = RALU_SA_RESET;
      SELBR_S = RALU_SBR_RESET;
      SELBI_S = RALU_SBI_RESET;
    end else if (CLMI_RHOLD || stall_raw) begin
      SELA_S  = RALU_SA_REGAHOLD;
      SELBR_S = RALU_SBR_REGBRHOLD;
      SELBI_S = RALU_SBI_REGBRHOLD;
    end else begin
      if (USE_SHAMT_S)   SELA_S = RALU_SA_IMMED;
      else if (USE_PC_S) SELA_S = RALU_SA_PCREL;
      else if (rs_hit_e) SELA_S = RALU_SA_ALURES;
      else if (rs_hit_m) SELA_S = rs_hit_m_load ? RALU_SA_DBUS : RALU_SA_ALUREGM;
      else if (rs_hit_w) SELA_S = RALU_SA_REGCWB;

      if (rt_hit_e)      SELBR_S = RALU_SBR_ALURES;
      else if (rt_hit_m) SELBR_S = rt_hit_m_load ? RALU_SBR_DBUS : RALU_SBR_ALUREGM;
      else if (rt_hit_w) SELBR_S = RALU_SBR_REGCWB;

      if (USE_IMM_S)     SELBI_S = RALU_SBI_IMMED;
      else if (rt_hit_e) SELBI_S = RALU_SBI_ALURES;
      else if (rt_hit_m) SELBI_S = rt_hit_m_load ? RALU_SBI_DBUS : RALU_SBI_ALUREGM;
      else if (rt_hit_w) SELBI_S = RALU_SBI_REGCWB;
    end
  end

  // Writeback register for the instruction now in M
  always_comb begin
    SELC_M = RALU_SC_HOLD;
    if (init_r) begin
      SELC_M = RALU_SC_RESET;
    end else if (!CLMI_RHOLD && ent_m.valid && ent_m.wen) begin
      SELC_M = ent_m.load ? RALU_SC_DBUS : RALU_SC_ALUREGM;
    end
  end

endmodule

// File: tb/tb_fwd_ctl.sv
// ---------------------------------------------------------------------------
// tb_fwd_ctl
// Self-checking bench for fwd_ctl. A table of per-cycle instruction vectors
// with hand-derived expected selects is replayed through the DUT; expected
// values go into a scoreboard queue when a vector is driven and are popped
// and compared when the outputs are sampled. Reset entry/exit and the
// asynchronous mid-operation reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fwd_ctl;

  // Select encodings written out independently of the design package
  localparam logic [8:0] A_IMMED = 9'h001, A_ALURES = 9'h002, A_ALUREGM = 9'h004,
                         A_HOLD  = 9'h008, A_DBUS   = 9'h010, A_CWB     = 9'h020,
                         A_PCREL = 9'h040, A_SF     = 9'h080, A_RST     = 9'h100;
  localparam logic [6:0] R_ALURES = 7'h01, R_ALUREGM = 7'h02, R_HOLD = 7'h04,
                         R_DBUS   = 7'h08, R_CWB     = 7'h10, R_SF   = 7'h20,
                         R_RST    = 7'h40;
  localparam logic [7:0] I_IMMED = 8'h01, I_ALURES = 8'h02, I_ALUREGM = 8'h04,
                         I_HOLD  = 8'h08, I_DBUS   = 8'h10, I_CWB     = 8'h20,
                         I_SF    = 8'h40, I_RST    = 8'h80;
  localparam logic [3:0] C_RST = 4'h1, C_DBUS = 4'h2, C_HOLD = 4'h4, C_ALUREGM = 4'h8;

  typedef struct {
    logic       hold;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic [4:0] rd;
    logic       wen;
    logic       load;
    logic       shamt;
    logic       pc;
    logic       imm;
    logic [8:0] expA;
    logic [6:0] expBr;
    logic [7:0] expBi;
    logic [3:0] expC;
    logic       expStall;
  } vec_t;

  typedef struct {
    int         tag;
    logic [8:0] a;
    logic [6:0] br;
    logic [7:0] bi;
    logic [3:0] c;
    logic       stall;
  } exp_t;

  logic       SYSCLK;
  logic       RESET_D1_R_N;
  logic       CLMI_RHOLD;
  logic       VALID_S;
  logic [4:0] RS_S;
  logic [4:0] RT_S;
  logic       USES_RS_S;
  logic       USES_RT_S;
  logic [4:0] RD_S;
  logic       WEN_S;
  logic       LOAD_S;
  logic       USE_SHAMT_S;
  logic       USE_PC_S;
  logic       USE_IMM_S;
  logic [8:0] SELA_S;
  logic [6:0] SELBR_S;
  logic [7:0] SELBI_S;
  logic [3:0] SELC_M;
  logic       STALL_S;

  vec_t table_q[$];
  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  fwd_ctl dut (
    .SYSCLK       (SYSCLK),
    .RESET_D1_R_N (RESET_D1_R_N),
    .CLMI_RHOLD   (CLMI_RHOLD),
    .VALID_S      (VALID_S),
    .RS_S         (RS_S),
    .RT_S         (RT_S),
    .USES_RS_S    (USES_RS_S),
    .USES_RT_S    (USES_RT_S),
    .RD_S         (RD_S),
    .WEN_S        (WEN_S),
    .LOAD_S       (LOAD_S),
    .USE_SHAMT_S  (USE_SHAMT_S),
    .USE_PC_S     (USE_PC_S),
    .USE_IMM_S    (USE_IMM_S),
    .SELA_S       (SELA_S),
    .SELBR_S      (SELBR_S),
    .SELBI_S      (SELBI_S),
    .SELC_M       (SELC_M),
    .STALL_S      (STALL_S)
  );

  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t makeVec(
    input logic hold, input logic valid, input logic [4:0] rs, input logic [4:0] rt,
    input logic usesRs, input logic usesRt, input logic [4:0] rd, input logic wen,
    input logic load, input logic shamt, input logic pc, input logic imm,
    input logic [8:0] a, input logic [6:0] br, input logic [7:0] bi,
    input logic [3:0] c, input logic stall);
    vec_t v;
    v.hold = hold;   v.valid = valid;   v.rs = rs;       v.rt = rt;
    v.usesRs = usesRs; v.usesRt = usesRt; v.rd = rd;     v.wen = wen;
    v.load = load;   v.shamt = shamt;   v.pc = pc;       v.imm = imm;
    v.expA = a;      v.expBr = br;      v.expBi = bi;    v.expC = c;
    v.expStall = stall;
    return v;
  endfunction

  // Drive one S-stage instruction and queue what the DUT must answer
  task automatic applyStimulus(input vec_t v, input int tag);
    exp_t e;
    CLMI_RHOLD  = v.hold;
    VALID_S     = v.valid;
    RS_S        = v.rs;
    RT_S        = v.rt;
    USES_RS_S   = v.usesRs;
    USES_RT_S   = v.usesRt;
    RD_S        = v.rd;
    WEN_S       = v.wen;
    LOAD_S      = v.load;
    USE_SHAMT_S = v.shamt;
    USE_PC_S    = v.pc;
    USE_IMM_S   = v.imm;
    e.tag   = tag;
    e.a     = v.expA;
    e.br    = v.expBr;
    e.bi    = v.expBi;
    e.c     = v.expC;
    e.stall = v.expStall;
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input int tag,
                            input logic [8:0] act, input logic [8:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = expQ.pop_front();
      checkField("SELA_S",  e.tag, SELA_S,           e.a);
      checkField("SELBR_S", e.tag, 9'(SELBR_S),      9'(e.br));
      checkField("SELBI_S", e.tag, 9'(SELBI_S),      9'(e.bi));
      checkField("SELC_M",  e.tag, 9'(SELC_M),       9'(e.c));
      checkField("STALL_S", e.tag, 9'(STALL_S),      9'(e.stall));
    end
  endtask

  task automatic addVec(
    input logic hold, input logic valid, input logic [4:0] rs, input logic [4:0] rt,
    input logic usesRs, input logic usesRt, input logic [4:0] rd, input logic wen,
    input logic load, input logic shamt, input logic pc, input logic imm,
    input logic [8:0] a, input logic [6:0] br, input logic [7:0] bi,
    input logic [3:0] c, input logic stall);
    table_q.push_back(makeVec(hold, valid, rs, rt, usesRs, usesRt, rd, wen, load,
                              shamt, pc, imm, a, br, bi, c, stall));
  endtask

  initial begin
    vec_t idleReset;
    vec_t v;

    // One row per cycle:
    //     hold val rs  rt  urs urt rd  wen ld  sh  pc  imm  A          BR         BI         C          stall
    addVec(0,  0,  1,  2,  1,  1,  0,  0,  0,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_HOLD,    0); // 1  empty pipe
    addVec(0,  1,  1,  2,  1,  1,  3,  1,  0,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_HOLD,    0); // 2  add r3
    addVec(0,  1,  3,  3,  1,  1,  4,  1,  0,  0,  0,  0,  A_ALURES,  R_ALURES,  I_ALURES,  C_HOLD,    0); // 3  add r4,r3,r3
    addVec(0,  1,  3,  1,  1,  1,  7,  1,  0,  0,  0,  0,  A_ALUREGM, R_SF,      I_SF,      C_ALUREGM, 0); // 4  r3 in M
    addVec(0,  1,  1,  3,  1,  1,  8,  1,  0,  0,  0,  0,  A_SF,      R_CWB,     I_CWB,     C_ALUREGM, 0); // 5  r3 in W
    addVec(0,  1,  2,  0,  1,  0,  5,  1,  1,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_ALUREGM, 0); // 6  lw r5
    addVec(0,  1,  5,  1,  1,  1,  6,  1,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_ALUREGM, 1); // 7  load-use stall
    addVec(0,  1,  5,  1,  1,  1,  6,  1,  0,  0,  0,  0,  A_DBUS,    R_SF,      I_SF,      C_DBUS,    0); // 8  replay, load in M
    addVec(0,  1,  1,  2,  1,  0,  0,  1,  1,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_HOLD,    0); // 9  lw r0
    addVec(0,  1,  0,  0,  1,  1, 10,  1,  0,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_ALUREGM, 0); // 10 reader of r0
    addVec(1,  1, 10,  6,  1,  1, 12,  1,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_HOLD,    0); // 11 hold
    addVec(1,  1, 10,  6,  1,  1, 12,  1,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_HOLD,    0); // 12 hold
    addVec(1,  1, 10,  6,  1,  1, 12,  1,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_HOLD,    0); // 13 hold
    addVec(0,  1, 10,  6,  1,  1, 12,  1,  0,  0,  0,  0,  A_ALURES,  R_CWB,     I_CWB,     C_DBUS,    0); // 14 released
    addVec(0,  1,  2, 12,  1,  1, 13,  1,  0,  0,  0,  1,  A_SF,      R_ALURES,  I_IMMED,   C_ALUREGM, 0); // 15 addi, RT in E
    addVec(0,  1, 13, 12,  1,  1, 14,  1,  0,  1,  0,  0,  A_IMMED,   R_ALUREGM, I_ALUREGM, C_ALUREGM, 0); // 16 shamt
    addVec(0,  1, 14, 13,  1,  1, 15,  0,  0,  0,  1,  0,  A_PCREL,   R_ALUREGM, I_ALUREGM, C_ALUREGM, 0); // 17 pc-rel, no write
    addVec(0,  1,  1,  2,  1,  1, 20,  1,  0,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_ALUREGM, 0); // 18 add r20
    addVec(0,  1,  1,  2,  1,  1, 20,  1,  0,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_HOLD,    0); // 19 add r20 again
    addVec(0,  1, 20, 20,  1,  1,  0,  0,  0,  0,  0,  0,  A_ALURES,  R_ALURES,  I_ALURES,  C_ALUREGM, 0); // 20 youngest wins
    addVec(0,  1,  1,  0,  1,  0, 22,  1,  1,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_ALUREGM, 0); // 21 lw r22
    addVec(1,  1, 20, 22,  1,  1,  0,  0,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_HOLD,    1); // 22 stall under hold
    addVec(0,  1, 20, 22,  1,  1,  0,  0,  0,  0,  0,  0,  A_HOLD,    R_HOLD,    I_HOLD,    C_HOLD,    1); // 23 stall, bubble
    addVec(0,  1, 20, 22,  1,  1,  0,  0,  0,  0,  0,  0,  A_SF,      R_DBUS,    I_DBUS,    C_DBUS,    0); // 24 RT from DBUS
    addVec(0,  1,  1,  0,  1,  0, 23,  1,  1,  0,  0,  0,  A_SF,      R_SF,      I_SF,      C_HOLD,    0); // 25 lw r23
    addVec(0,  1, 23,  1,  1,  1, 24,  1,  0,  1,  0,  0,  A_IMMED,   R_SF,      I_SF,      C_HOLD,    0); // 26 shamt skips RS stall
    addVec(0,  0, 23,  0,  1,  0, 24,  1,  0,  0,  0,  0,  A_DBUS,    R_SF,      I_SF,      C_DBUS,    0); // 27 invalid S
    addVec(0,  0, 24,  0,  1,  0,  0,  0,  0,  0,  0,  0,  A_ALUREGM, R_SF,      I_SF,      C_ALUREGM, 0); // 28 previous was bubble

    idleReset = makeVec(0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, A_RST, R_RST, I_RST, C_RST, 0);

    // Reset asserted across clock edges
    RESET_D1_R_N = 1'b0;
    applyStimulus(idleReset, 100);
    @(posedge SYSCLK);
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    checkOutput();

    // Released but no edge yet: still in the init cycle
    #1 RESET_D1_R_N = 1'b1;
    applyStimulus(idleReset, 101);
    #1 checkOutput();

    @(posedge SYSCLK);
    for (int i = 0; i < table_q.size(); i++) begin
      #1 applyStimulus(table_q[i], i + 1);
      @(negedge SYSCLK);
      checkOutput();
      @(posedge SYSCLK);
    end

    // Asynchronous reset mid-operation; W still holds r24 here
    v = makeVec(0, 1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_CWB, R_SF, I_SF, C_HOLD, 0);
    #1 applyStimulus(v, 200);
    @(negedge SYSCLK);
    checkOutput();
    #1 RESET_D1_R_N = 1'b0;
    applyStimulus(makeVec(0, 1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                          A_RST, R_RST, I_RST, C_RST, 0), 201);
    #1 checkOutput();
    @(posedge SYSCLK);
    #2 RESET_D1_R_N = 1'b1;
    applyStimulus(makeVec(0, 0, 24, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                          A_RST, R_RST, I_RST, C_RST, 0), 202);
    #1 checkOutput();
    @(posedge SYSCLK);
    // Tracking was wiped, so r24 is no longer bypassed
    #1 applyStimulus(makeVec(0, 1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                             A_SF, R_SF, I_SF, C_HOLD, 0), 203);
    @(negedge SYSCLK);
    checkOutput();

    if (expQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
